// File: rtl/minesweeper_board_renderer.sv
// minesweeper_board_renderer
//   Minesweeper board renderer that sits between vga_driver and the VGA colour pins.
//   - Incremental counters map the pixel stream to board cells, so no divide or modulo is needed.
//   - An inferred RAM holds one 2-bit state per cell.
//   - A two-stage pipeline produces a 24-bit {R,G,B} colour.
//   Optional feature: define CURSOR_HIGHLIGHT_EN to draw a yellow border around the cursor cell.
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   active_pixels, xPixel, yPixel  pixel stream from vga_driver
//   hsync_in, vsync_in             sync from vga_driver
//   hsync_out, vsync_out           sync delayed 2 clk
//   vga_color                      {R,G,B}; aligned with hsync_out/vsync_out
//   wr_en, wr_x, wr_y, wr_state    cell-state write (0 HIDDEN, 1 REVEALED, 2 FLAGGED, 3 MINE)
//   mv_up/down/left/right          one-clk cursor move pulses
//   cursor_x, cursor_y             cursor cell
//   ready                          high once the RAM clear has finished
module minesweeper_board_renderer #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int CELL_W     = 40,
  parameter int CELL_H     = 30,
  parameter int CUR_BORDER = 2,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int N  = GRID_W * GRID_H,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active_pixels,
  input  logic [9:0]    xPixel,
  input  logic [9:0]    yPixel,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [23:0]   vga_color,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [1:0]    wr_state,
  input  logic          mv_up,
  input  logic          mv_down,
  input  logic          mv_left,
  input  logic          mv_right,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          ready
);

  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_HIDDEN  = 24'h878080;
  localparam logic [23:0] COL_REVEAL  = 24'hC0C0C0;
  localparam logic [23:0] COL_FLAG    = 24'hFF0000;
  localparam logic [23:0] COL_CURSOR  = 24'hFFFF00;

  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_reg, state_next;
  logic [AW-1:0] clr_addr_reg, clr_addr_next;

  // ---------------------------------------------------------------------------
  // Pixel -> cell trackers. They advance only when the coordinate changes,
  // which relies on the coordinate stepping by +1 or returning to 0.
  // ---------------------------------------------------------------------------
  logic [9:0] x_prev_reg, local_x_reg, cell_x_reg, local_x_next, cell_x_next;
  logic [9:0] y_prev_reg, local_y_reg, cell_y_reg, local_y_next, cell_y_next;

  always_comb begin
    local_x_next = local_x_reg;
    cell_x_next  = cell_x_reg;
    if (xPixel != x_prev_reg) begin
      if (xPixel == 10'd0) begin
        local_x_next = '0;
        cell_x_next  = '0;
      end else if (local_x_reg == 10'(CELL_W - 1)) begin
        local_x_next = '0;
        cell_x_next  = cell_x_reg + 10'd1;
      end else begin
        local_x_next = local_x_reg + 10'd1;
      end
    end
    local_y_next = local_y_reg;
    cell_y_next  = cell_y_reg;
    if (yPixel != y_prev_reg) begin
      if (yPixel == 10'd0) begin
        local_y_next = '0;
        cell_y_next  = '0;
      end else if (local_y_reg == 10'(CELL_H - 1)) begin
        local_y_next = '0;
        cell_y_next  = cell_y_reg + 10'd1;
      end else begin
        local_y_next = local_y_reg + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cell-state RAM. There is one write port, shared by the clear sweep and by
  // user writes. A read of the same cell that is being written returns the old data.
  // ---------------------------------------------------------------------------
  logic [1:0]    ram_mem [0:N-1];
  logic [1:0]    ram_q;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [1:0]    ram_wdata;
  logic [AW-1:0] rd_addr;
  logic          x_ok, y_ok;

  // The range check is only needed when the coordinate field can exceed the grid.
  generate
    if ((1 << XW) > GRID_W) begin : g_x_chk
      assign x_ok = (32'(wr_x) < GRID_W);
    end else begin : g_x_full
      assign x_ok = 1'b1;
    end
    if ((1 << YW) > GRID_H) begin : g_y_chk
      assign y_ok = (32'(wr_y) < GRID_H);
    end else begin : g_y_full
      assign y_ok = 1'b1;
    end
  endgenerate

  // The read address is taken from the tracker values being loaded this clk.
  // As a result, the RAM output lines up with the registered tracker.
  assign rd_addr = AW'(cell_y_next) * AW'(GRID_W) + AW'(cell_x_next);

  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    ram_q <= ram_mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Control FSM: clear sweep, then run.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    ram_we        = 1'b0;
    ram_waddr     = clr_addr_reg;
    ram_wdata     = 2'd0;
    case (state_reg)
      CLEAR: begin
        ram_we        = 1'b1;
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == AW'(N - 1)) begin
          state_next    = RUN;
          clr_addr_next = '0;
        end
      end
      RUN: begin
        if (wr_en && x_ok && y_ok) begin
          ram_we    = 1'b1;
          ram_waddr = AW'(wr_y) * AW'(GRID_W) + AW'(wr_x);
          ram_wdata = wr_state;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cursor with wrap-around. Opposite pulses on the same axis cancel out.
  // ---------------------------------------------------------------------------
  logic [XW-1:0] cursor_x_reg, cursor_x_next;
  logic [YW-1:0] cursor_y_reg, cursor_y_next;

  always_comb begin
    cursor_x_next = cursor_x_reg;
    cursor_y_next = cursor_y_reg;
    if (state_reg == RUN) begin
      if (mv_left && !mv_right)
        cursor_x_next = (cursor_x_reg == '0) ? XW'(GRID_W - 1) : cursor_x_reg - 1'b1;
      else if (mv_right && !mv_left)
        cursor_x_next = (cursor_x_reg == XW'(GRID_W - 1)) ? '0 : cursor_x_reg + 1'b1;
      if (mv_up && !mv_down)
        cursor_y_next = (cursor_y_reg == '0) ? YW'(GRID_H - 1) : cursor_y_reg - 1'b1;
      else if (mv_down && !mv_up)
        cursor_y_next = (cursor_y_reg == YW'(GRID_H - 1)) ? '0 : cursor_y_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour from the registered tracker, the RAM data and active.
  // ---------------------------------------------------------------------------
  logic        active_reg, hs_d1_reg, vs_d1_reg;
  logic        hsync_out_reg, vsync_out_reg;
  logic [23:0] color_reg, color_next;
  logic        in_board, grid_line;

  assign in_board  = (cell_x_reg < 10'(GRID_W)) && (cell_y_reg < 10'(GRID_H));
  assign grid_line = (local_x_reg == 10'd0) || (local_y_reg == 10'd0);

  always_comb begin
    color_next = COL_BLACK;
    if (state_reg == RUN && active_reg && in_board) begin
      if (grid_line) begin
        color_next = COL_WHITE;
      end else begin
        case (ram_q)
          2'd0:    color_next = COL_HIDDEN;
          2'd1:    color_next = COL_REVEAL;
          2'd2:    color_next = COL_FLAG;
          default: color_next = COL_BLACK;
        endcase
      end
`ifdef CURSOR_HIGHLIGHT_EN
      if (cell_x_reg == 10'(cursor_x_reg) && cell_y_reg == 10'(cursor_y_reg) &&
          (local_x_reg <  10'(CUR_BORDER) || local_x_reg >= 10'(CELL_W - CUR_BORDER) ||
           local_y_reg <  10'(CUR_BORDER) || local_y_reg >= 10'(CELL_H - CUR_BORDER)))
        color_next = COL_CURSOR;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      clr_addr_reg  <= '0;
      x_prev_reg    <= '0;
      y_prev_reg    <= '0;
      local_x_reg   <= '0;
      cell_x_reg    <= '0;
      local_y_reg   <= '0;
      cell_y_reg    <= '0;
      cursor_x_reg  <= '0;
      cursor_y_reg  <= '0;
      active_reg    <= 1'b0;
      hs_d1_reg     <= 1'b0;
      vs_d1_reg     <= 1'b0;
      hsync_out_reg <= 1'b0;
      vsync_out_reg <= 1'b0;
      color_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      clr_addr_reg  <= clr_addr_next;
      x_prev_reg    <= xPixel;
      y_prev_reg    <= yPixel;
      local_x_reg   <= local_x_next;
      cell_x_reg    <= cell_x_next;
      local_y_reg   <= local_y_next;
      cell_y_reg    <= cell_y_next;
      cursor_x_reg  <= cursor_x_next;
      cursor_y_reg  <= cursor_y_next;
      active_reg    <= active_pixels;
      hs_d1_reg     <= hsync_in;
      vs_d1_reg     <= vsync_in;
      hsync_out_reg <= hs_d1_reg;
      vsync_out_reg <= vs_d1_reg;
      color_reg     <= color_next;
    end
  end

  assign hsync_out = hsync_out_reg;
  assign vsync_out = vsync_out_reg;
  assign vga_color = color_reg;
  assign cursor_x  = cursor_x_reg;
  assign cursor_y  = cursor_y_reg;
  assign ready     = (state_reg == RUN);

endmodule

// File: tb/tb_minesweeper_board_renderer.sv
// Directed testbench for minesweeper_board_renderer (default parameters).
module tb_minesweeper_board_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        active_pixels;
  logic [9:0]  xPixel, yPixel;
  logic        hsync_in, vsync_in, hsync_out, vsync_out;
  logic [23:0] vga_color;
  logic        wr_en;
  logic [3:0]  wr_x, wr_y;
  logic [1:0]  wr_state;
  logic        mv_up, mv_down, mv_left, mv_right;
  logic [3:0]  cursor_x, cursor_y;
  logic        ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  minesweeper_board_renderer dut (
    .clk(clk), .rst(rst), .active_pixels(active_pixels),
    .xPixel(xPixel), .yPixel(yPixel),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .vga_color(vga_color),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_state(wr_state),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Walk the pixel stream from (0,0) to (tx,ty) one step at a time, then let
  // the 2-clk pipeline settle.
  task automatic goto_px(input int tx, input int ty);
    xPixel = '0;
    yPixel = '0;
    tick();
    for (int yy = 1; yy <= ty; yy++) begin
      yPixel = 10'(yy);
      tick();
    end
    for (int xx = 1; xx <= tx; xx++) begin
      xPixel = 10'(xx);
      tick();
    end
    tick();
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    mv_up = u; mv_down = d; mv_left = l; mv_right = r;
    tick();
    mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
  endtask

  task automatic write_cell(input int x, input int y, input int s);
    wr_x = 4'(x); wr_y = 4'(y); wr_state = 2'(s); wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  logic [23:0] exp_c;

  initial begin
    rst = 1'b1; active_pixels = 1'b1; xPixel = '0; yPixel = '0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_state = '0;
    mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
    tick();
    ticks(2);
    // Reset state
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_color", 32'(vga_color), 32'h0);
    chk("rst_hsync", 32'(hsync_out), 32'd0);
    chk("rst_vsync", 32'(vsync_out), 32'd0);
    chk("rst_cursor", {24'd0, cursor_x, cursor_y}, 32'h00);
    hsync_in = 1'b0; vsync_in = 1'b0;
    rst = 1'b0;

    // Clear lasts 256 clks. Writes and moves issued during the clear must be ignored.
    ticks(200);
    wr_x = 4'd0; wr_y = 4'd0; wr_state = 2'd3; wr_en = 1'b1;
    mv_right = 1'b1;
    tick();
    wr_en = 1'b0; mv_right = 1'b0;
    chk("clear_move_ignored", 32'(cursor_x), 32'd0);
    chk("clear_color_black", 32'(vga_color), 32'h0);
    ticks(54);
    chk("ready_low_255", 32'(ready), 32'd0);
    tick();
    chk("ready_high_256", 32'(ready), 32'd1);

    // Basic colours
    goto_px(20, 15);
    chk("cell00_hidden_wr_ignored", 32'(vga_color), 32'h878080);
    goto_px(40, 31);
    chk("px40_31_gridline", 32'(vga_color), 32'hFFFFFF);
    xPixel = 10'd41; ticks(2);
    chk("px41_31_hidden", 32'(vga_color), 32'h878080);
    active_pixels = 1'b0; ticks(2);
    chk("inactive_black", 32'(vga_color), 32'h0);
    active_pixels = 1'b1;
    goto_px(639, 35);
    chk("px639_35_hidden", 32'(vga_color), 32'h878080);
    xPixel = 10'd640; ticks(2);
    chk("px640_offboard", 32'(vga_color), 32'h0);
    goto_px(41, 479);
    chk("px41_479_hidden", 32'(vga_color), 32'h878080);
    yPixel = 10'd480; ticks(2);
    chk("px41_480_offboard", 32'(vga_color), 32'h0);

    // Sync delay
    hsync_in = 1'b1; tick();
    chk("hsync_d1", 32'(hsync_out), 32'd0);
    tick();
    chk("hsync_d2", 32'(hsync_out), 32'd1);
    hsync_in = 1'b0; vsync_in = 1'b1; ticks(2);
    chk("vsync_d2", {30'd0, hsync_out, vsync_out}, 32'd1);
    vsync_in = 1'b0;

    // Cell writes and scan of the flagged cell
    write_cell(3, 2, 2);
    write_cell(4, 2, 3);
    write_cell(5, 2, 1);
    for (int y = 61; y <= 89; y++) begin
      goto_px(121, y);
      exp_c = ((121 % 40) == 0 || (y % 30) == 0) ? 24'hFFFFFF : 24'hFF0000;
      chk("scan_flag", 32'(vga_color), 32'(exp_c));
      for (int x = 122; x <= 159; x++) begin
        xPixel = 10'(x); ticks(2);
        exp_c = ((x % 40) == 0 || (y % 30) == 0) ? 24'hFFFFFF : 24'hFF0000;
        chk("scan_flag", 32'(vga_color), 32'(exp_c));
      end
    end
    goto_px(120, 61);
    chk("flag_cell_gridline", 32'(vga_color), 32'hFFFFFF);
    goto_px(181, 61);
    chk("mine_cell", 32'(vga_color), 32'h0);
    goto_px(201, 61);
    chk("revealed_cell", 32'(vga_color), 32'hC0C0C0);
    goto_px(241, 61);
    chk("cell62_hidden", 32'(vga_color), 32'h878080);

    // Cursor moves
    pulse(0, 0, 1, 0);
    chk("cur_left_wrap", {24'd0, cursor_x, cursor_y}, 32'hF0);
    pulse(1, 1, 0, 0);
    chk("cur_updown_cancel", {24'd0, cursor_x, cursor_y}, 32'hF0);
    pulse(0, 1, 0, 0);
    chk("cur_down", {24'd0, cursor_x, cursor_y}, 32'hF1);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    chk("cur_up_wrap", {24'd0, cursor_x, cursor_y}, 32'hFF);
    pulse(0, 0, 0, 1);
    chk("cur_right_wrap", {24'd0, cursor_x, cursor_y}, 32'h0F);
    pulse(0, 0, 1, 1);
    chk("cur_lr_cancel", {24'd0, cursor_x, cursor_y}, 32'h0F);
    pulse(0, 1, 0, 1);
    chk("cur_diag", {24'd0, cursor_x, cursor_y}, 32'h10);
    pulse(0, 0, 1, 0);
    chk("cur_home", {24'd0, cursor_x, cursor_y}, 32'h00);

    // Cursor highlight (or its absence)
    goto_px(1, 15);
`ifdef CURSOR_HIGHLIGHT_EN
    chk("hl_1_15", 32'(vga_color), 32'hFFFF00);
`else
    chk("hl_1_15", 32'(vga_color), 32'h878080);
`endif
    goto_px(0, 15);
`ifdef CURSOR_HIGHLIGHT_EN
    chk("hl_0_15", 32'(vga_color), 32'hFFFF00);
`else
    chk("hl_0_15", 32'(vga_color), 32'hFFFFFF);
`endif
    goto_px(20, 15);
    chk("hl_20_15", 32'(vga_color), 32'h878080);
    goto_px(41, 1);
    chk("hl_other_cell", 32'(vga_color), 32'h878080);

    // Reset in the middle of a clear restarts the sweep
    pulse(0, 0, 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_cursor", {24'd0, cursor_x, cursor_y}, 32'h00);
    ticks(100);
    rst = 1'b1; tick(); rst = 1'b0;
    ticks(255);
    chk("rst3_ready_low_255", 32'(ready), 32'd0);
    tick();
    chk("rst3_ready_high_256", 32'(ready), 32'd1);
    goto_px(121, 61);
    chk("reclear_flag_hidden", 32'(vga_color), 32'h878080);
    goto_px(201, 61);
    chk("reclear_reveal_hidden", 32'(vga_color), 32'h878080);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
